// File: rtl/bayt_degistir_seri.sv
// bayt_degistir_seri: sequential AES SubBytes engine.
// One 128-bit state is substituted LANES bytes per cycle over 16/LANES beats,
// with valid/ready handshakes on both the input and the output side.
// Optional feature macro: BAYT_TERS_EN adds inverse S-boxes (InvSubBytes)
// selected per block by the ters input latched at acceptance.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1; valid, once raised, holds its data stable until
// that edge, and ready may depend combinationally on the other side's ready.
module bayt_degistir_seri #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] girisler,
   input  logic         ters,
   input  logic         giris_gecerli,
   output logic         giris_hazir,
   output logic [127:0] cikislar,
   output logic         cikis_gecerli,
   input  logic         cikis_hazir,
   output logic         mesgul
);

   localparam int N  = 16 / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int LW = 8 * LANES;
   localparam logic [CW-1:0] SON_BEAT = CW'(N - 1);

   localparam logic [1:0] BOS     = 2'd0;
   localparam logic [1:0] CALISMA = 2'd1;
   localparam logic [1:0] TAMAM   = 2'd2;

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_bad
      $error("bayt_degistir_seri: LANES must be 1, 2, 4, 8 or 16");
   end

   // GF(2^8) arithmetic with the AES polynomial x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

`ifdef BAYT_TERS_EN
   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
   endfunction
`endif

   logic [1:0]    durum;
   logic [127:0]  isler;
   logic [CW-1:0] sayac;
   logic [LW-1:0] ust;
   logic [LW-1:0] sub;
   logic [6:0]    yaz_ust;
   logic          kabul;

   assign ust     = isler[127 -: LW];
   assign yaz_ust = 7'(127 - LW * int'(sayac));

   // Ready is decoded from state so a finished block can hand off and a new
   // one can enter on the same edge; held low throughout reset.
   assign giris_hazir = rst_n && ((durum == BOS) || ((durum == TAMAM) && cikis_hazir));
   assign kabul       = giris_gecerli && giris_hazir;

`ifdef BAYT_TERS_EN
   logic mod;

   // Mode latched once per block; ters changes mid-block are ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mod <= 1'b0;
      end else if (kabul) begin
         mod <= ters;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign sub[8*g +: 8] = mod ? inv_sbox(ust[8*g +: 8]) : fwd_sbox(ust[8*g +: 8]);
   end
`else
   logic ters_unused;
   assign ters_unused = ters;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign sub[8*g +: 8] = fwd_sbox(ust[8*g +: 8]);
   end
`endif

   // Control FSM, work register shifting and output byte placement.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         durum         <= BOS;
         isler         <= '0;
         sayac         <= '0;
         cikislar      <= '0;
         cikis_gecerli <= 1'b0;
         mesgul        <= 1'b0;
      end else begin
         case (durum)
            BOS: begin
            end
            CALISMA: begin
               cikislar[yaz_ust -: LW] <= sub;
               isler <= isler << LW;
               sayac <= sayac + 1'b1;
               if (sayac == SON_BEAT) begin
                  durum         <= TAMAM;
                  cikis_gecerli <= 1'b1;
               end
            end
            TAMAM: begin
               if (cikis_hazir) begin
                  cikis_gecerli <= 1'b0;
                  durum         <= BOS;
                  mesgul        <= 1'b0;
               end
            end
            default: begin
               durum <= BOS;
            end
         endcase
         // Acceptance overrides the return to BOS when a new block is waiting.
         if (kabul) begin
            isler  <= girisler;
            sayac  <= '0;
            durum  <= CALISMA;
            mesgul <= 1'b1;
         end
      end
   end

endmodule
